// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and the majority-vote helper.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 50;
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned BIT_IDX_W            = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } uart_state_e;

    function automatic logic majority3(input logic [2:0] taps);
        return (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX pin synchroniser plus sample-point tap. UART_RX_MAJORITY_EN selects a 3-tap
// majority vote centred on the same instant as the plain middle tap.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx_pin,
    output logic rx_s,
    output logic rx_samp_c
);

    logic meta_q, meta_d;
    logic rx_s_q, rx_s_d;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] tap_q, tap_d;
`else
    logic       tap_q, tap_d;
`endif

    always_comb begin
        meta_d = rx_pin;
        rx_s_d = meta_q;
`ifdef UART_RX_MAJORITY_EN
        tap_d  = {tap_q[0], rx_s_q};
`else
        tap_d  = rx_s_q;
`endif
    end

    // Preset to the idle (high) line level so reset never fakes a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            tap_q  <= '1;
        end else begin
            meta_q <= meta_d;
            rx_s_q <= rx_s_d;
            tap_q  <= tap_d;
        end
    end

    assign rx_s = rx_s_q;
`ifdef UART_RX_MAJORITY_EN
    assign rx_samp_c = majority3({tap_q[1], tap_q[0], rx_s_q});
`else
    assign rx_samp_c = tap_q;
`endif

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver, 8N1 LSB first, mid-bit sampling. Optional glitch filter: UART_RX_MAJORITY_EN.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 i_Clock,
    input  logic                 reset_n,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_DV,
    output logic                 o_Rx_Active,
    output logic                 o_Frame_Err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;

    logic rx_s;
    logic rx_samp_c;

    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_byte_q, rx_byte_d;
    logic                   rx_dv_q, rx_dv_d;
    logic                   active_q, active_d;
    logic                   frame_err_q, frame_err_d;

    uart_rx_sync u_sync (
        .clk       (i_Clock),
        .rst_n     (reset_n),
        .rx_pin    (i_Rx_Serial),
        .rx_s      (rx_s),
        .rx_samp_c (rx_samp_c)
    );

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        active_d    = active_q;
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d  = S_START;
                    active_d = 1'b1;
                end
            end

            S_START: begin
                if (clk_cnt_q == CNT_W'(HALF)) begin
                    clk_cnt_d = '0;
                    if (!rx_samp_c) begin
                        state_d = S_DATA;
                    end else begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_samp_c;
                    if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            // A low stop bit discards the byte; the previous good byte stays visible.
            S_STOP: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = S_CLEANUP;
                    if (rx_samp_c) begin
                        rx_byte_d = shift_q;
                        rx_dv_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            // Wait for a high line so a held break yields a single error.
            S_CLEANUP: begin
                if (rx_s) begin
                    state_d  = S_IDLE;
                    active_d = 1'b0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            active_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            active_q    <= active_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_Rx_Byte   = rx_byte_q;
    assign o_Rx_DV     = rx_dv_q;
    assign o_Rx_Active = active_q;
    assign o_Frame_Err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serial line model, expected-strobe scoreboard, immediate assertions.
module tb_uart_rx_core;

    localparam int unsigned CPB = 50;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       rx_active;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         is_fe;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] last_good = 8'h00;
    logic       dv_prev   = 1'b0;
    logic       fe_prev   = 1'b0;

    always #10 clk = ~clk;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .reset_n     (rst_n),
        .i_Rx_Serial (rx),
        .o_Rx_Byte   (rx_byte),
        .o_Rx_DV     (rx_dv),
        .o_Rx_Active (rx_active),
        .o_Frame_Err (frame_err)
    );

    // Strobe monitor: every DV / Frame_Err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_dv || frame_err) begin
                checks++;
                assert ((rx_dv && frame_err) === 1'b0) else begin
                    errors++;
                    $error("FAIL both_strobes observed dv=%0b fe=%0b expected not both", rx_dv, frame_err);
                end
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_strobe observed dv=%0b fe=%0b byte=%02h expected none", rx_dv, frame_err, rx_byte);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert (frame_err === e.is_fe) else begin
                        errors++;
                        $error("FAIL strobe_kind observed fe=%0b expected fe=%0b", frame_err, e.is_fe);
                    end
                    checks++;
                    assert (rx_byte === e.data) else begin
                        errors++;
                        $error("FAIL strobe_byte observed=%02h expected=%02h", rx_byte, e.data);
                    end
                end
            end
            if (dv_prev || fe_prev) begin
                checks++;
                assert ((rx_dv || frame_err) === 1'b0) else begin
                    errors++;
                    $error("FAIL strobe_width observed dv=%0b fe=%0b expected 0", rx_dv, frame_err);
                end
            end
        end
        dv_prev = rx_dv;
        fe_prev = frame_err;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame; glitch inverts the pin for the single clock captured at each data mid-bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit glitch);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (glitch) begin
                tick(CPB / 2 - 1);
                rx = ~d[i];
                tick(1);
                rx = d[i];
                tick(CPB / 2);
            end else begin
                tick(CPB);
            end
        end
        rx = stop_bit;
        tick(CPB);
    endtask

    task automatic send_good(input logic [7:0] d);
        sb.push_back('{is_fe: 1'b0, data: d});
        last_good = d;
        send_frame(d, 1'b1, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || rx_active) && n < 2000) begin
            tick(1);
            n++;
        end
        checks++;
        assert ((sb.size() == 0 && !rx_active) === 1'b1) else begin
            errors++;
            $error("FAIL %s_timeout observed pending=%0d active=%0b expected 0/0", tag, sb.size(), rx_active);
        end
    endtask

    initial begin
        logic [7:0] gbyte;

        rst_n = 1'b0;
        rx    = 1'b1;
        tick(5);
        check("reset_byte",   32'(rx_byte),   32'h00);
        check("reset_dv",     32'(rx_dv),     32'h0);
        check("reset_active", 32'(rx_active), 32'h0);
        check("reset_fe",     32'(frame_err), 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Single byte
        send_good(8'hA5);
        wait_idle("a5");
        check("a5_byte",   32'(rx_byte),   32'hA5);
        check("a5_active", 32'(rx_active), 32'h0);

        // Back-to-back with no idle gap
        send_good(8'h00);
        send_good(8'hFF);
        wait_idle("b2b");
        check("b2b_byte", 32'(rx_byte), 32'hFF);

        // Short low glitch on the idle line must abort in START
        rx = 1'b0;
        tick(10);
        check("glitch_active_hi", 32'(rx_active), 32'h1);
        rx = 1'b1;
        tick(40);
        check("glitch_active_lo", 32'(rx_active), 32'h0);
        check("glitch_byte",      32'(rx_byte),   32'hFF);

        // Bad stop bit followed by a held break
        sb.push_back('{is_fe: 1'b1, data: last_good});
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        tick(500);
        check("break_active", 32'(rx_active), 32'h1);
        check("break_fe_seen", 32'(sb.size()), 32'h0);
        check("break_byte_kept", 32'(rx_byte), 32'(last_good));
        rx = 1'b1;
        tick(5);
        wait_idle("break");
        send_good(8'h81);
        wait_idle("after_break");
        check("after_break_byte", 32'(rx_byte), 32'h81);

        // Reset during bit 4 of 0x5A
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'h5A >> i) & 8'h01) != 8'h00;
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB / 2);
        rst_n = 1'b0;
        #1;
        last_good = 8'h00;
        check("midreset_byte",   32'(rx_byte),   32'h00);
        check("midreset_dv",     32'(rx_dv),     32'h0);
        check("midreset_active", 32'(rx_active), 32'h0);
        check("midreset_fe",     32'(frame_err), 32'h0);
        tick(5);
        rst_n = 1'b1;
        tick(5);
        send_good(8'h12);
        wait_idle("post_reset");
        check("post_reset_byte", 32'(rx_byte), 32'h12);

        // Single-cycle inversions at each data sample point
`ifdef UART_RX_MAJORITY_EN
        gbyte = 8'h96;
`else
        gbyte = 8'h69;
`endif
        sb.push_back('{is_fe: 1'b0, data: gbyte});
        send_frame(8'h96, 1'b1, 1'b1);
        wait_idle("midbit_glitch");
        check("midbit_glitch_byte", 32'(rx_byte), 32'(gbyte));

        tick(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
